// File: rtl/apb_slave.sv
// apb_slave: APB3 completer over a 2**ADDR_W x DATA_W scratch register file.
// Latency: capture one edge after SETUP entry; pready in first ACCESS cycle, or WAIT_CYCLES later when APB_SLAVE_WAIT_EN is defined.
// Backpressure: pready stays low through wait states; the requester holds the ACCESS phase until pready=1.
module apb_slave #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              psel,
   input  logic              penable,
   input  logic [DATA_W-1:0] pwdata,
   input  logic              pwrite,
   output logic [DATA_W-1:0] prdata,
   output logic              pready
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_prdata;
   logic              w_capture;
   logic              w_done;

   // Wait-state count must fit the 4-bit counter.
   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range
      $error("apb_slave: WAIT_CYCLES out of range 0..15");
   end

   // The transfer is latched on the SETUP->ACCESS edge; later bus changes are ignored.
   assign w_capture = (r_state == S_SETUP) && psel && penable;

`ifdef APB_SLAVE_WAIT_EN
   logic [3:0] r_wait_cnt;

   assign w_done = (r_state == S_ACCESS) && (r_wait_cnt == 4'd0);

   // Wait counter: load on capture, count down through ACCESS until zero.
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_wait_cnt <= 4'd0;
      end else if (w_capture) begin
         r_wait_cnt <= 4'(WAIT_CYCLES);
      end else if ((r_state == S_ACCESS) && (r_wait_cnt != 4'd0)) begin
         r_wait_cnt <= r_wait_cnt - 4'd1;
      end
   end
`else
   assign w_done = (r_state == S_ACCESS);
`endif

   // Register file: cleared by reset, written only on a write capture edge.
   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_capture && pwrite) begin
         r_mem[paddr] <= pwdata;
      end
   end

   // Read data is registered on a read capture edge and held until the next read.
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_prdata <= '0;
      end else if (w_capture && !pwrite) begin
         r_prdata <= r_mem[paddr];
      end
   end

   // Protocol FSM: IDLE -> SETUP -> ACCESS, with back-to-back SETUP from a completing ACCESS.
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               // psel with penable already high is a protocol violation; stay parked.
               if (psel && !penable) begin
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (psel && penable) begin
                  r_state <= S_ACCESS;
               end else if (!psel) begin
                  r_state <= S_IDLE;
               end
            end
            S_ACCESS: begin
               if (w_done) begin
                  if (psel && !penable) begin
                     r_state <= S_SETUP;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign prdata = r_prdata;
   assign pready = w_done;

endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: directed bench for apb_slave.
// Per-cycle vector table for the zero-wait build plus hand-written transfer sequences.
// Inputs driven 1 time unit after the rising edge; outputs compared at the same point.
module tb_apb_slave;

   logic       pclk = 1'b0;
   logic       preset;
   logic [3:0] paddr;
   logic       psel;
   logic       penable;
   logic [7:0] pwdata;
   logic       pwrite;
   logic [7:0] prdata;
   logic       pready;

   int n_checks = 0;
   int n_errors = 0;

`ifdef APB_SLAVE_WAIT_EN
   localparam int EXP_WAIT = 2;
`else
   localparam int EXP_WAIT = 0;
`endif

   apb_slave #(
      .ADDR_W      (4),
      .DATA_W      (8),
      .WAIT_CYCLES (2)
   ) dut (
      .pclk    (pclk),
      .preset  (preset),
      .paddr   (paddr),
      .psel    (psel),
      .penable (penable),
      .pwdata  (pwdata),
      .pwrite  (pwrite),
      .prdata  (prdata),
      .pready  (pready)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic       rst;
      logic       sel;
      logic       en;
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wd;
      logic       exp_rdy;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic sel, input logic en, input logic wr,
                               input logic [3:0] addr, input logic [7:0] wd,
                               input logic exp_rdy, input logic [7:0] exp_rd);
      vec_t v;
      v.rst = rst; v.sel = sel; v.en = en; v.wr = wr;
      v.addr = addr; v.wd = wd; v.exp_rdy = exp_rdy; v.exp_rd = exp_rd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic sel, input logic en, input logic wr,
                        input logic [3:0] addr, input logic [7:0] wd);
      preset  = rst;
      psel    = sel;
      penable = en;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wd;
   endtask

   task automatic step;
      @(posedge pclk);
      #1;
   endtask

   // One complete transfer with a bounded wait for pready.
   task automatic xfer(input logic wr, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input string nm);
      int waits;
      bit done;
      drive(1'b0, 1'b1, 1'b0, wr, a, d);
      step();
      chk({nm, "_setup_pready"}, {31'd0, pready}, 32'd0);
      drive(1'b0, 1'b1, 1'b1, wr, a, d);
      step();
      waits = 0;
      done  = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         if (pready === 1'b1) done = 1'b1;
         else begin
            waits++;
            step();
         end
      end
      if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
      chk({nm, "_waits"}, waits, EXP_WAIT);
      if (!wr) chk({nm, "_prdata"}, {24'd0, prdata}, {24'd0, exp_rd});
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      step();
      chk({nm, "_pulse_end"}, {31'd0, pready}, 32'd0);
   endtask

   initial begin
      // Reset held for two cycles.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      step();
      step();
      chk("reset_pready", {31'd0, pready}, 32'd0);
      chk("reset_prdata", {24'd0, prdata}, 32'd0);

`ifndef APB_SLAVE_WAIT_EN
      //                 rst sel en wr addr  wdata  rdy prdata
      tbl.push_back(mk(1, 0, 0, 0, 4'd0,  8'd0,   0, 8'd0));
      tbl.push_back(mk(1, 0, 0, 0, 4'd0,  8'd0,   0, 8'd0));
      tbl.push_back(mk(0, 0, 0, 0, 4'd0,  8'd0,   0, 8'd0));
      // read of an address after reset returns 0
      tbl.push_back(mk(0, 1, 0, 0, 4'd3,  8'd0,   0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 0, 4'd3,  8'd0,   1, 8'd0));
      // write 220 to 5 (back-to-back from the read)
      tbl.push_back(mk(0, 1, 0, 1, 4'd5,  8'd220, 0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 1, 4'd5,  8'd220, 1, 8'd0));
      tbl.push_back(mk(0, 0, 0, 0, 4'd0,  8'd0,   0, 8'd0));
      // read 5
      tbl.push_back(mk(0, 1, 0, 0, 4'd5,  8'd0,   0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 0, 4'd5,  8'd0,   1, 8'd220));
      tbl.push_back(mk(0, 0, 0, 0, 4'd0,  8'd0,   0, 8'd220));
      // write 77 to 5, then pwrite/pwdata change after the capture edge
      tbl.push_back(mk(0, 1, 0, 1, 4'd5,  8'd77,  0, 8'd220));
      tbl.push_back(mk(0, 1, 1, 1, 4'd5,  8'd77,  1, 8'd220));
      tbl.push_back(mk(0, 1, 1, 0, 4'd5,  8'd0,   0, 8'd220));
      tbl.push_back(mk(0, 0, 0, 0, 4'd0,  8'd0,   0, 8'd220));
      tbl.push_back(mk(0, 1, 0, 0, 4'd5,  8'd0,   0, 8'd220));
      tbl.push_back(mk(0, 1, 1, 0, 4'd5,  8'd0,   1, 8'd77));
      tbl.push_back(mk(0, 0, 0, 0, 4'd0,  8'd0,   0, 8'd77));
      // back-to-back: write 0x3C to 15, then reads of 15, 14, 0
      tbl.push_back(mk(0, 1, 0, 1, 4'd15, 8'h3C,  0, 8'd77));
      tbl.push_back(mk(0, 1, 1, 1, 4'd15, 8'h3C,  1, 8'd77));
      tbl.push_back(mk(0, 1, 0, 0, 4'd15, 8'd0,   0, 8'd77));
      tbl.push_back(mk(0, 1, 1, 0, 4'd15, 8'd0,   1, 8'h3C));
      tbl.push_back(mk(0, 1, 0, 0, 4'd14, 8'd0,   0, 8'h3C));
      tbl.push_back(mk(0, 1, 1, 0, 4'd14, 8'd0,   1, 8'd0));
      tbl.push_back(mk(0, 1, 0, 0, 4'd0,  8'd0,   0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 0, 4'd0,  8'd0,   1, 8'd0));
      // stuck strobe after a write of 0x55 to 2
      tbl.push_back(mk(0, 1, 0, 1, 4'd2,  8'h55,  0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 1, 4'd2,  8'h55,  1, 8'd0));
      tbl.push_back(mk(0, 1, 1, 1, 4'd2,  8'hAA,  0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 1, 4'd2,  8'hAA,  0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 1, 4'd2,  8'hAA,  0, 8'd0));
      tbl.push_back(mk(0, 1, 0, 0, 4'd2,  8'd0,   0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 0, 4'd2,  8'd0,   1, 8'h55));
      tbl.push_back(mk(0, 0, 0, 0, 4'd0,  8'd0,   0, 8'h55));
      // reset during ACCESS, then IDLE ignores psel+penable
      tbl.push_back(mk(0, 1, 0, 1, 4'd7,  8'h99,  0, 8'h55));
      tbl.push_back(mk(0, 1, 1, 1, 4'd7,  8'h99,  1, 8'h55));
      tbl.push_back(mk(1, 1, 0, 0, 4'd7,  8'd0,   0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 0, 4'd7,  8'd0,   0, 8'd0));
      tbl.push_back(mk(0, 1, 0, 0, 4'd7,  8'd0,   0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 0, 4'd7,  8'd0,   1, 8'd0));
      // reset on what would be the write capture edge: no commit
      tbl.push_back(mk(0, 1, 0, 1, 4'd7,  8'h99,  0, 8'd0));
      tbl.push_back(mk(1, 1, 1, 1, 4'd7,  8'h99,  0, 8'd0));
      tbl.push_back(mk(0, 0, 0, 0, 4'd0,  8'd0,   0, 8'd0));
      tbl.push_back(mk(0, 1, 0, 0, 4'd7,  8'd0,   0, 8'd0));
      tbl.push_back(mk(0, 1, 1, 0, 4'd7,  8'd0,   1, 8'd0));
      tbl.push_back(mk(0, 0, 0, 0, 4'd0,  8'd0,   0, 8'd0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].sel, tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].wd);
         step();
         chk($sformatf("vec%0d_pready", i), {31'd0, pready}, {31'd0, tbl[i].exp_rdy});
         chk($sformatf("vec%0d_prdata", i), {24'd0, prdata}, {24'd0, tbl[i].exp_rd});
      end
`endif

      // Full transfers with the build's wait-state count.
      xfer(1'b1, 4'd9,  8'hA5, 8'd0,  "wr9");
      xfer(1'b1, 4'd10, 8'h5A, 8'd0,  "wr10");
      xfer(1'b0, 4'd9,  8'd0,  8'hA5, "rd9");
      xfer(1'b0, 4'd10, 8'd0,  8'h5A, "rd10");
      xfer(1'b0, 4'd11, 8'd0,  8'd0,  "rd11");

`ifdef APB_SLAVE_WAIT_EN
      // Reset while waiting in ACCESS.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 8'd0);
      step();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 8'd0);
      step();
      chk("midacc_wait_pready", {31'd0, pready}, 32'd0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 8'd0);
      step();
      chk("midacc_rst_pready", {31'd0, pready}, 32'd0);
      chk("midacc_rst_prdata", {24'd0, prdata}, 32'd0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 8'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("midacc_idle%0d_pready", k), {31'd0, pready}, 32'd0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
      step();
      xfer(1'b0, 4'd9, 8'd0, 8'd0, "rd9_after_rst");
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
